// File: rtl/nanci_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nanci_read_responder                                         |
// | Description : Answers read-request packets addressed to this PE with the   |
// |               local memory word, queued in order through a small FIFO.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nanci_read_responder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MY_ADDR    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [2*ADDR_WIDTH-1:0]          req_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0]            memory,
    output logic [7:0]                       served_cnt,
    output logic [3:0]                       misroute_cnt
);

    localparam int c_IDX_W   = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W   = c_IDX_W + 1;
    localparam int c_ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_MY_ADDR = ADDR_WIDTH'(MY_ADDR);

    logic [DATA_WIDTH-1:0] r_memory;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [7:0]            r_served_cnt;
    logic [3:0]            r_misroute_cnt;
    logic [c_ENTRY_W-1:0]  r_fifo [FIFO_DEPTH];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_for_me;
    logic [ADDR_WIDTH-1:0] w_dst;
    logic [ADDR_WIDTH-1:0] w_src;

    assign w_dst    = req_data[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign w_src    = req_data[ADDR_WIDTH-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) &&
                      (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
    assign w_for_me = (w_dst == c_MY_ADDR);

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
    assign req_ready = !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && w_for_me;
    assign w_pop     = !w_empty && rsp_ready;

    assign rsp_valid    = !w_empty;
    assign rsp_data     = w_empty ? '0 : r_fifo[r_rd_ptr[c_IDX_W-1:0]];
    assign memory       = r_memory;
    assign served_cnt   = r_served_cnt;
    assign misroute_cnt = r_misroute_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memory       <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_served_cnt   <= '0;
            r_misroute_cnt <= '0;
        end else begin
            if (wr_valid) begin
                r_memory <= wr_data;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
                r_served_cnt <= r_served_cnt + 8'd1;
            end
            if (w_accept && !w_for_me && (r_misroute_cnt != 4'hF)) begin
                r_misroute_cnt <= r_misroute_cnt + 4'd1;
            end
        end
    end

    // Entry captures the memory word as it was before any same-edge write.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_IDX_W-1:0]] <= {w_src, r_memory};
        end
    end

endmodule
`default_nettype wire
